demux_8_32_arbiter: RTL and testbench

//  Shares one 8->32 byte-to-word demux path between two byte-stream requesters (lane 0, lane 1).

---
 rtl/demux_arb_pkg.sv | 14 +
 rtl/word_pack_8_32.sv | 43 ++++
 rtl/demux_8_32_arbiter.sv | 137 +++++++++++++
 tb/tb_demux_8_32_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_arb_pkg.sv
// Shared constants for the two-lane 8->32 demux arbiter.
package demux_arb_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    // Arbiter state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

endpackage

// File: rtl/word_pack_8_32.sv
// Packs accepted bytes big-endian into a 32-bit word.
// The first byte of a word lands in [31:24], the last in [7:0].
// word_next is the word including the byte being written this cycle,
// so the caller can capture a completed word on the same edge as done.
module word_pack_8_32
    import demux_arb_pkg::*;
(
    input  logic              clk_4f,
    input  logic              reset_L,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic [WORD_W-1:0] word_next,
    output logic              done
);

    logic [WORD_W-1:0] word_q;

    // Merge the incoming byte into its lane slot
    always_comb begin
        word_next = word_q;
        if (wr_en) begin
            word_next[(BYTES_PER_WORD - 1 - int'(byte_cnt)) * BYTE_W +: BYTE_W] = byte_in;
        end
    end

    assign done = wr_en && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

    // Byte position counter and shadow word; the counter wraps on completion
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            byte_cnt <= '0;
            word_q   <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (wr_en) begin
            byte_cnt <= byte_cnt + 1'b1;
            word_q   <= word_next;
        end
    end

endmodule

// File: rtl/demux_8_32_arbiter.sv
// Two-lane round-robin arbiter in front of a shared 8->32 byte packer.
// A granted lane keeps the path until its word completes or it stalls
// for TIMEOUT cycles, in which case any partial word is dropped.
//
//   state  | meaning
//   IDLE   | no owner; arbitrate on the current valids (no byte accepted)
//   GRANT0 | lane 0 owns the packer, ready0 high
//   GRANT1 | lane 1 owns the packer, ready1 high
module demux_8_32_arbiter
    import demux_arb_pkg::*;
#(
    parameter int TIMEOUT    = 8,
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic              clk_4f,
    input  logic              reset_L,
    input  logic [BYTE_W-1:0] data_in0,
    input  logic              valid_in0,
    output logic              ready0,
    input  logic [BYTE_W-1:0] data_in1,
    input  logic              valid_in1,
    output logic              ready1,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              src_out,
    output logic              err_out,
    output logic              err_src
);

    localparam int TMO_W = $clog2(TIMEOUT);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              last_grant;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              granted;
    logic              gnt_lane;
    logic              lane_valid;
    logic              other_valid;
    logic [BYTE_W-1:0] lane_byte;
    logic              accept;
    logic              tmo_hit;
    logic              done;
    logic [CNT_W-1:0]  byte_cnt;
    logic [WORD_W-1:0] word_next;

    // Ready comes straight from the registered state: no valid->ready path
    assign ready0      = (state == ST_GRANT0);
    assign ready1      = (state == ST_GRANT1);
    assign granted     = ready0 | ready1;
    assign gnt_lane    = ready1;
    assign lane_valid  = gnt_lane ? valid_in1 : valid_in0;
    assign other_valid = gnt_lane ? valid_in0 : valid_in1;
    assign lane_byte   = gnt_lane ? data_in1 : data_in0;
    assign accept      = granted && lane_valid;
    assign tmo_hit     = granted && !lane_valid && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    word_pack_8_32 u_pack (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .clear     (tmo_hit),
        .wr_en     (accept),
        .byte_in   (lane_byte),
        .byte_cnt  (byte_cnt),
        .word_next (word_next),
        .done      (done)
    );

    // Next-state: round-robin on ties, hand over at word boundaries, release on timeout
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (valid_in0 && valid_in1) begin
                    state_nxt = last_grant ? ST_GRANT0 : ST_GRANT1;
                end else if (valid_in0) begin
                    state_nxt = ST_GRANT0;
                end else if (valid_in1) begin
                    state_nxt = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (done) begin
                    if (other_valid) begin
                        state_nxt = gnt_lane ? ST_GRANT0 : ST_GRANT1;
                    end else if (!lane_valid) begin
                        state_nxt = ST_IDLE;
                    end
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, round-robin pointer and stall counter
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state      <= ST_IDLE;
            last_grant <= ~FIRST_PRIO;
            tmo_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (done || tmo_hit) begin
                last_grant <= gnt_lane;
            end
            if (!granted || lane_valid || tmo_hit) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_W'(TIMEOUT - 1)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // Output word / error strobes; data and source ids hold between pulses
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            src_out   <= 1'b0;
            err_out   <= 1'b0;
            err_src   <= 1'b0;
        end else begin
            valid_out <= done;
            err_out   <= tmo_hit && (byte_cnt != '0);
            if (done) begin
                data_out <= word_next;
                src_out  <= gnt_lane;
            end
            if (tmo_hit && (byte_cnt != '0)) begin
                err_src <= gnt_lane;
            end
        end
    end

endmodule

// File: tb/tb_demux_8_32_arbiter.sv
// Bench for demux_8_32_arbiter: directed scenarios plus a randomized run
// against a queue-based lane/word model.
module tb_demux_8_32_arbiter;

    localparam int TIMEOUT    = 8;
    localparam bit FIRST_PRIO = 1'b0;

    logic        clk_4f;
    logic        reset_L;
    logic [7:0]  data_in0;
    logic        valid_in0;
    logic        ready0;
    logic [7:0]  data_in1;
    logic        valid_in1;
    logic        ready1;
    logic [31:0] data_out;
    logic        valid_out;
    logic        src_out;
    logic        err_out;
    logic        err_src;

    int n_cmp = 0;
    int n_err = 0;

    demux_8_32_arbiter #(
        .TIMEOUT    (TIMEOUT),
        .FIRST_PRIO (FIRST_PRIO)
    ) dut (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .data_in0  (data_in0),
        .valid_in0 (valid_in0),
        .ready0    (ready0),
        .data_in1  (data_in1),
        .valid_in1 (valid_in1),
        .ready1    (ready1),
        .data_out  (data_out),
        .valid_out (valid_out),
        .src_out   (src_out),
        .err_out   (err_out),
        .err_src   (err_src)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: current owner (-1 none), bytes collected so far,
    // consecutive idle cycles of the owner, and the last lane served.
    int         m_owner;
    logic [7:0] m_q[$];
    int         m_idle;
    int         m_last;
    logic [31:0] m_data;
    bit         m_valid, m_src, m_err, m_esrc;

    task automatic model_reset();
        m_owner = -1;
        m_q.delete();
        m_idle  = 0;
        m_last  = FIRST_PRIO ? 0 : 1;
        m_data  = 32'h0;
        m_valid = 0; m_src = 0; m_err = 0; m_esrc = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        bit own_v, oth_v;
        logic [7:0] own_d;
        m_valid = 0;
        m_err   = 0;
        if (m_owner < 0) begin
            if (valid_in0 && valid_in1) m_owner = (m_last == 0) ? 1 : 0;
            else if (valid_in0)         m_owner = 0;
            else if (valid_in1)         m_owner = 1;
        end else begin
            own_v = (m_owner == 1) ? valid_in1 : valid_in0;
            oth_v = (m_owner == 1) ? valid_in0 : valid_in1;
            own_d = (m_owner == 1) ? data_in1 : data_in0;
            if (own_v) begin
                m_idle = 0;
                m_q.push_back(own_d);
                if (m_q.size() == 4) begin
                    m_data  = {m_q[0], m_q[1], m_q[2], m_q[3]};
                    m_valid = 1;
                    m_src   = (m_owner == 1);
                    m_last  = m_owner;
                    m_q.delete();
                    if (oth_v) m_owner = 1 - m_owner;
                end
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    if (m_q.size() != 0) begin
                        m_err  = 1;
                        m_esrc = (m_owner == 1);
                    end
                    m_q.delete();
                    m_last  = m_owner;
                    m_owner = -1;
                    m_idle  = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic do_reset();
        valid_in0 = 0; valid_in1 = 0;
        data_in0  = 8'h00; data_in1 = 8'h00;
        reset_L   = 0;
        tick();
        tick();
        reset_L = 1;
        tick();
    endtask

    // Drive one word on a lane, waiting (bounded) for ready on each byte
    task automatic send_word(input bit lane, input logic [31:0] w, output bit ok);
        bit acc;
        ok = 1;
        for (int i = 0; i < 4; i++) begin
            if (lane) begin valid_in1 = 1; data_in1 = w[31-8*i -: 8]; end
            else      begin valid_in0 = 1; data_in0 = w[31-8*i -: 8]; end
            acc = 0;
            for (int k = 0; k < 20 && !acc; k++) begin
                acc = lane ? ready1 : ready0;
                tick();
            end
            if (!acc) ok = 0;
        end
        if (lane) valid_in1 = 0; else valid_in0 = 0;
    endtask

    task automatic test_reset();
        bit ok;
        do_reset();
        n_cmp++;
        if ({ready0, ready1, valid_out, err_out, src_out, err_src, data_out} !== 38'h0) begin
            n_err++;
            $display("FAIL reset_state: got r=%b%b v=%b e=%b s=%b es=%b d=%h required all zero",
                     ready0, ready1, valid_out, err_out, src_out, err_src, data_out);
        end
        send_word(1'b1, 32'h5AC3_0F96, ok);
        n_cmp++;
        if (!ok || valid_out !== 1'b1 || data_out !== 32'h5AC3_0F96 || src_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_preword: got ok=%b v=%b d=%h s=%b required 1 1 5ac30f96 1",
                     ok, valid_out, data_out, src_out);
        end
        valid_in1 = 1; data_in1 = 8'h77;
        tick();
        data_in1 = 8'h88;
        tick();
        valid_in1 = 0;
        #2 reset_L = 0;
        #1;
        n_cmp++;
        if ({ready0, ready1, valid_out, err_out, src_out, err_src, data_out} !== 38'h0) begin
            n_err++;
            $display("FAIL reset_midword: got r=%b%b v=%b e=%b s=%b es=%b d=%h required all zero",
                     ready0, ready1, valid_out, err_out, src_out, err_src, data_out);
        end
        tick();
        reset_L = 1;
        tick();
        send_word(1'b0, 32'h0A0B_0C0D, ok);
        n_cmp++;
        if (!ok || valid_out !== 1'b1 || data_out !== 32'h0A0B_0C0D || src_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_fresh_word: got ok=%b v=%b d=%h s=%b required 1 1 0a0b0c0d 0",
                     ok, valid_out, data_out, src_out);
        end
    endtask

    task automatic test_single_lane();
        do_reset();
        valid_in0 = 1; data_in0 = 8'hEE;
        tick();
        n_cmp++;
        if (ready0 !== 1'b1 || ready1 !== 1'b0) begin
            n_err++;
            $display("FAIL single_grant: got ready0=%b ready1=%b required 1 0", ready0, ready1);
        end
        tick();
        data_in0 = 8'hFF; tick();
        data_in0 = 8'hFD; tick();
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL single_early_valid: got %b required 0", valid_out);
        end
        data_in0 = 8'hCC; tick();
        valid_in0 = 0;
        n_cmp++;
        if (valid_out !== 1'b1 || data_out !== 32'hEEFF_FDCC || src_out !== 1'b0) begin
            n_err++;
            $display("FAIL single_word: got v=%b d=%h s=%b required 1 eefffdcc 0",
                     valid_out, data_out, src_out);
        end
        tick();
        n_cmp++;
        if (valid_out !== 1'b0 || data_out !== 32'hEEFF_FDCC) begin
            n_err++;
            $display("FAIL single_hold: got v=%b d=%h required 0 eefffdcc", valid_out, data_out);
        end
    endtask

    task automatic test_contention();
        logic [31:0] w0, w1;
        int i0, i1, n;
        bit a0, a1;
        int cyc[4];
        logic [31:0] dat[4];
        bit src[4];
        w0 = 32'hEEFF_FDCC;
        w1 = 32'hAA12_BB01;
        i0 = 0; i1 = 0; n = 0;
        do_reset();
        valid_in0 = 1; valid_in1 = 1;
        for (int c = 0; c < 60 && n < 4; c++) begin
            data_in0 = w0[31-8*i0 -: 8];
            data_in1 = w1[31-8*i1 -: 8];
            a0 = ready0; a1 = ready1;
            tick();
            if (a0) i0 = (i0 + 1) % 4;
            if (a1) i1 = (i1 + 1) % 4;
            if (valid_out === 1'b1) begin
                cyc[n] = c; dat[n] = data_out; src[n] = src_out;
                n++;
            end
        end
        valid_in0 = 0; valid_in1 = 0;
        n_cmp++;
        if (n != 4) begin
            n_err++;
            $display("FAIL contention_count: got %0d words required 4", n);
        end
        for (int k = 0; k < n; k++) begin
            n_cmp++;
            if (src[k] !== k[0] || dat[k] !== (k[0] ? w1 : w0)) begin
                n_err++;
                $display("FAIL contention_word%0d: got src=%b d=%h required src=%b d=%h",
                         k, src[k], dat[k], k[0], (k[0] ? w1 : w0));
            end
            if (k > 0) begin
                n_cmp++;
                if (cyc[k] - cyc[k-1] != 4) begin
                    n_err++;
                    $display("FAIL contention_spacing%0d: got %0d cycles required 4",
                             k, cyc[k] - cyc[k-1]);
                end
            end
        end
        tick();
    endtask

    task automatic test_gaps();
        logic [8:0] pat[7];
        bit seen_err, seen_val;
        pat = '{9'h1AA, 9'h000, 9'h000, 9'h112, 9'h1BB, 9'h000, 9'h101};
        seen_err = 0; seen_val = 0;
        do_reset();
        valid_in1 = 1; data_in1 = 8'hAA;
        tick();
        for (int i = 0; i < 7; i++) begin
            valid_in1 = pat[i][8];
            data_in1  = pat[i][7:0];
            tick();
            seen_err |= err_out;
            if (i < 6) seen_val |= valid_out;
        end
        valid_in1 = 0;
        n_cmp++;
        if (seen_err || seen_val || valid_out !== 1'b1 || data_out !== 32'hAA12_BB01 || src_out !== 1'b1) begin
            n_err++;
            $display("FAIL gaps_word: got err=%b early=%b v=%b d=%h s=%b required 0 0 1 aa12bb01 1",
                     seen_err, seen_val, valid_out, data_out, src_out);
        end
        tick();
    endtask

    task automatic test_timeout();
        bit seen_err, seen_val, ok;
        seen_err = 0; seen_val = 0;
        do_reset();
        valid_in0 = 1; data_in0 = 8'hEE;
        tick();
        tick();
        data_in0 = 8'hFF;
        tick();
        valid_in0 = 0;
        valid_in1 = 1; data_in1 = 8'hAA;
        repeat (TIMEOUT - 1) begin
            tick();
            seen_err |= err_out;
            seen_val |= valid_out;
        end
        n_cmp++;
        if (seen_err || ready0 !== 1'b1 || ready1 !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_hold: got err=%b ready0=%b ready1=%b required 0 1 0",
                     seen_err, ready0, ready1);
        end
        tick();
        n_cmp++;
        if (err_out !== 1'b1 || err_src !== 1'b0 || valid_out !== 1'b0 || seen_val || ready0 !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_err: got err=%b esrc=%b v=%b anyv=%b ready0=%b required 1 0 0 0 0",
                     err_out, err_src, valid_out, seen_val, ready0);
        end
        tick();
        n_cmp++;
        if (ready1 !== 1'b1 || err_out !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_regrant: got ready1=%b err=%b required 1 0", ready1, err_out);
        end
        send_word(1'b1, 32'hAA12_BB01, ok);
        n_cmp++;
        if (!ok || valid_out !== 1'b1 || data_out !== 32'hAA12_BB01 || src_out !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_fresh: got ok=%b v=%b d=%h s=%b required 1 1 aa12bb01 1",
                     ok, valid_out, data_out, src_out);
        end
        tick();
    endtask

    task automatic test_silent_release();
        bit seen_err, ok;
        seen_err = 0;
        do_reset();
        valid_in0 = 1; data_in0 = 8'h33;
        tick();
        valid_in0 = 0;
        valid_in1 = 1; data_in1 = 8'h12;
        repeat (TIMEOUT - 1) begin
            tick();
            seen_err |= err_out;
        end
        n_cmp++;
        if (ready0 !== 1'b1 || ready1 !== 1'b0) begin
            n_err++;
            $display("FAIL silent_hold: got ready0=%b ready1=%b required 1 0", ready0, ready1);
        end
        tick();
        seen_err |= err_out;
        n_cmp++;
        if (seen_err || ready0 !== 1'b0) begin
            n_err++;
            $display("FAIL silent_release: got err=%b ready0=%b required 0 0", seen_err, ready0);
        end
        tick();
        n_cmp++;
        if (ready1 !== 1'b1) begin
            n_err++;
            $display("FAIL silent_serve: got ready1=%b required 1", ready1);
        end
        send_word(1'b1, 32'h1234_5678, ok);
        n_cmp++;
        if (!ok || valid_out !== 1'b1 || data_out !== 32'h1234_5678 || src_out !== 1'b1) begin
            n_err++;
            $display("FAIL silent_word: got ok=%b v=%b d=%h s=%b required 1 1 12345678 1",
                     ok, valid_out, data_out, src_out);
        end
        tick();
    endtask

    task automatic test_random();
        int p0, p1;
        int plist[4];
        int words, errs;
        plist = '{0, 10, 50, 95};
        words = 0; errs = 0;
        p0 = 95; p1 = 95;
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) begin
                p0 = plist[$urandom_range(0, 3)];
                p1 = plist[$urandom_range(0, 3)];
            end
            valid_in0 = ($urandom_range(0, 99) < p0);
            valid_in1 = ($urandom_range(0, 99) < p1);
            data_in0  = 8'($urandom);
            data_in1  = 8'($urandom);
            model_step();
            tick();
            if (m_valid) words++;
            if (m_err)   errs++;
            n_cmp++;
            if (ready0 !== (m_owner == 0) || ready1 !== (m_owner == 1)) begin
                n_err++;
                $display("FAIL rand_ready c=%0d: got %b%b required owner %0d", c, ready0, ready1, m_owner);
            end
            n_cmp++;
            if (valid_out !== m_valid || data_out !== m_data || src_out !== m_src) begin
                n_err++;
                $display("FAIL rand_word c=%0d: got v=%b d=%h s=%b required v=%b d=%h s=%b",
                         c, valid_out, data_out, src_out, m_valid, m_data, m_src);
            end
            n_cmp++;
            if (err_out !== m_err || err_src !== m_esrc) begin
                n_err++;
                $display("FAIL rand_err c=%0d: got e=%b es=%b required e=%b es=%b",
                         c, err_out, err_src, m_err, m_esrc);
            end
        end
        valid_in0 = 0; valid_in1 = 0;
        n_cmp++;
        if (words == 0 || errs == 0) begin
            n_err++;
            $display("FAIL rand_coverage: got words=%0d drops=%0d required both nonzero", words, errs);
        end
    endtask

    initial begin
        reset_L   = 0;
        valid_in0 = 0; valid_in1 = 0;
        data_in0  = 8'h00; data_in1 = 8'h00;
        test_reset();
        test_single_lane();
        test_contention();
        test_gaps();
        test_timeout();
        test_silent_release();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
